conv_mac_scheduler: RTL and testbench

Sequencer that shares one pipelined multiply-accumulate unit among all (filter, input-channel) pairs of a convolution layer. For each window position it issues NUM_FILTERS×IN_CHANNEL MAC jobs back-to-back, one per cycle, and tracks the in-order results. It accumulates the results per filter across channels, then applies ReLU plus saturation and presents the packed filter outputs on a ready/valid port. It sits between the per-channel window buffers, the weight ROM and the shared mult_acc unit, and replaces one-job-at-a-time sequencing with a fully pipelined issue.

---
 rtl/conv_mac_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_conv_mac_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_scheduler.sv
// conv_mac_scheduler: issues every (filter, channel) MAC job of one window position
// back-to-back to a shared pipelined MAC, accumulates in-order results and emits ReLU/saturated pixels.
module conv_mac_scheduler #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_FILTERS    = 3,
  parameter int IN_CHANNEL     = 3,
  parameter int MAC_WIDTH      = 16,
  parameter int ACC_WIDTH      = 20,
  parameter int RESULT_LATENCY = 5,
  localparam int FI_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int CI_W = (IN_CHANNEL > 1) ? $clog2(IN_CHANNEL) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              frame_start,
  input  logic                              win_ready,
  output logic                              win_consume,
  output logic                              mac_issue,
  output logic [FI_W-1:0]                   mac_filter_idx,
  output logic [CI_W-1:0]                   mac_channel_idx,
  input  logic                              result_valid,
  input  logic signed [MAC_WIDTH-1:0]       result_data,
  output logic [NUM_FILTERS*DATA_WIDTH-1:0] conv_out,
  output logic                              conv_valid,
  input  logic                              conv_ready,
  output logic                              sched_err
);

  localparam int NUM_JOBS = NUM_FILTERS * IN_CHANNEL;
  // In-flight jobs never exceed the job count nor the pipeline depth; size for the larger.
  localparam int MAX_OUT = (NUM_JOBS > RESULT_LATENCY) ? NUM_JOBS : RESULT_LATENCY;
  localparam int OUT_W   = $clog2(MAX_OUT + 1);
  localparam logic [FI_W-1:0] F_LAST = FI_W'(NUM_FILTERS - 1);
  localparam logic [CI_W-1:0] C_LAST = CI_W'(IN_CHANNEL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t                            state_r;
  state_t                            next_state_s;
  logic [FI_W-1:0]                   issue_f_r;
  logic [CI_W-1:0]                   issue_c_r;
  logic [FI_W-1:0]                   ret_f_r;
  logic [CI_W-1:0]                   ret_c_r;
  logic [OUT_W-1:0]                  outstanding_r;
  logic [OUT_W-1:0]                  outstanding_next_s;
  logic signed [ACC_WIDTH-1:0]       acc_r [NUM_FILTERS];
  logic                              mac_issue_r;
  logic                              win_consume_r;
  logic                              conv_valid_r;
  logic                              sched_err_r;
  logic [NUM_FILTERS*DATA_WIDTH-1:0] conv_out_r;

  logic                              slot_free_s;
  logic                              start_s;
  logic                              last_issue_s;
  logic                              spurious_s;
  logic                              ret_ok_s;
  logic                              accept_s;
  logic                              final_s;
  logic signed [ACC_WIDTH-1:0]       result_ext_s;
  logic signed [ACC_WIDTH-1:0]       last_sum_s;

  // ReLU followed by unsigned saturation to DATA_WIDTH bits.
  function automatic logic [DATA_WIDTH-1:0] relu_sat(input logic signed [ACC_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    if (v[ACC_WIDTH-1]) begin
      r = {DATA_WIDTH{1'b0}};
    end else if (|v[ACC_WIDTH-2:DATA_WIDTH]) begin
      r = {DATA_WIDTH{1'b1}};
    end else begin
      r = v[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  assign result_ext_s = {{(ACC_WIDTH-MAC_WIDTH){result_data[MAC_WIDTH-1]}}, result_data};
  assign slot_free_s  = !conv_valid_r || conv_ready;
  assign last_issue_s = mac_issue_r && (issue_f_r == F_LAST) && (issue_c_r == C_LAST);
  // A result with nothing in flight (and no issue this cycle) is ignored and flagged.
  assign spurious_s   = result_valid && (outstanding_r == OUT_W'(0)) && !mac_issue_r;
  assign ret_ok_s     = result_valid && !spurious_s;
  assign accept_s     = ret_ok_s && !frame_start && (state_r != FLUSH);
  assign final_s      = accept_s && (ret_f_r == F_LAST) && (ret_c_r == C_LAST);
  assign last_sum_s   = (ret_c_r == CI_W'(0)) ? result_ext_s
                                              : acc_r[NUM_FILTERS-1] + result_ext_s;
  assign start_s      = (state_r == IDLE) && (next_state_s == ISSUE);

  // Outstanding-job count after this cycle's issue and result.
  always_comb begin
    outstanding_next_s = outstanding_r;
    if (mac_issue_r && !ret_ok_s) begin
      outstanding_next_s = outstanding_r + OUT_W'(1);
    end else if (!mac_issue_r && ret_ok_s) begin
      outstanding_next_s = outstanding_r - OUT_W'(1);
    end else begin
      outstanding_next_s = outstanding_r;
    end
  end

  // Next-state logic; frame_start overrides every state.
  always_comb begin
    next_state_s = state_r;
    if (frame_start) begin
      next_state_s = (outstanding_next_s != OUT_W'(0)) ? FLUSH : IDLE;
    end else begin
      case (state_r)
        IDLE:    next_state_s = (win_ready && slot_free_s) ? ISSUE : IDLE;
        ISSUE:   next_state_s = last_issue_s ? DRAIN : ISSUE;
        DRAIN:   next_state_s = final_s ? IDLE : DRAIN;
        FLUSH:   next_state_s = (outstanding_next_s == OUT_W'(0)) ? IDLE : FLUSH;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // State register and single-bit control/status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      mac_issue_r   <= 1'b0;
      win_consume_r <= 1'b0;
      sched_err_r   <= 1'b0;
      outstanding_r <= OUT_W'(0);
    end else begin
      state_r       <= next_state_s;
      mac_issue_r   <= (next_state_s == ISSUE);
      win_consume_r <= last_issue_s && !frame_start;
      sched_err_r   <= sched_err_r | spurious_s;
      outstanding_r <= outstanding_next_s;
    end
  end

  // Issue-side job counters: channel inner, filter outer; they hold after the last job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_f_r <= FI_W'(0);
      issue_c_r <= CI_W'(0);
    end else if (frame_start || start_s) begin
      issue_f_r <= FI_W'(0);
      issue_c_r <= CI_W'(0);
    end else if (mac_issue_r && !last_issue_s) begin
      if (issue_c_r == C_LAST) begin
        issue_c_r <= CI_W'(0);
        issue_f_r <= issue_f_r + FI_W'(1);
      end else begin
        issue_c_r <= issue_c_r + CI_W'(1);
      end
    end
  end

  // Return-side counters follow results, which come back in issue order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_f_r <= FI_W'(0);
      ret_c_r <= CI_W'(0);
    end else if (frame_start || final_s) begin
      ret_f_r <= FI_W'(0);
      ret_c_r <= CI_W'(0);
    end else if (accept_s) begin
      if (ret_c_r == C_LAST) begin
        ret_c_r <= CI_W'(0);
        ret_f_r <= ret_f_r + FI_W'(1);
      end else begin
        ret_c_r <= ret_c_r + CI_W'(1);
      end
    end
  end

  // Per-filter accumulators: channel 0 loads, later channels add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < NUM_FILTERS; f++) acc_r[f] <= '0;
    end else if (frame_start) begin
      for (int f = 0; f < NUM_FILTERS; f++) acc_r[f] <= '0;
    end else if (accept_s) begin
      for (int f = 0; f < NUM_FILTERS; f++) begin
        if (FI_W'(f) == ret_f_r) begin
          acc_r[f] <= (ret_c_r == CI_W'(0)) ? result_ext_s : acc_r[f] + result_ext_s;
        end
      end
    end
  end

  // Output slot: all filters load together on the final result, held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_out_r   <= '0;
      conv_valid_r <= 1'b0;
    end else if (frame_start) begin
      conv_valid_r <= 1'b0;
    end else if (final_s) begin
      for (int f = 0; f < NUM_FILTERS; f++) begin
        conv_out_r[f*DATA_WIDTH +: DATA_WIDTH] <=
          relu_sat((f == NUM_FILTERS - 1) ? last_sum_s : acc_r[f]);
      end
      conv_valid_r <= 1'b1;
    end else if (conv_valid_r && conv_ready) begin
      conv_valid_r <= 1'b0;
    end
  end

  assign mac_issue       = mac_issue_r;
  assign mac_filter_idx  = issue_f_r;
  assign mac_channel_idx = issue_c_r;
  assign win_consume     = win_consume_r;
  assign conv_out        = conv_out_r;
  assign conv_valid      = conv_valid_r;
  assign sched_err       = sched_err_r;

endmodule

// File: tb/tb_conv_mac_scheduler.sv
// Bench for conv_mac_scheduler: a fixed-latency MAC responder, expected pixels from a
// per-position sum/ReLU/clamp model pushed to a queue, and a monitor that pops on each handshake.
`timescale 1ns/1ps
module tb_conv_mac_scheduler;
  localparam int DW = 8, NF = 3, IC = 3, MW = 16, AW = 20, L = 5, N = NF * IC;

  logic clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, win_ready = 1'b0;
  logic result_valid = 1'b0, conv_ready = 1'b0;
  logic signed [MW-1:0] result_data = '0;
  logic win_consume, mac_issue, conv_valid, sched_err;
  logic [1:0] mac_filter_idx, mac_channel_idx;
  logic [NF*DW-1:0] conv_out;

  int n_checks = 0, n_err = 0, n_acc = 0, exp_acc = 0, cyc = 0;
  int spur_req = 0, spur_done = 0;
  bit rand_ready = 1'b0;
  int tbl [NF][IC];
  logic [NF*DW-1:0] exp_q [$];
  typedef struct { int due; int data; } pend_t;
  pend_t pend_q [$];

  conv_mac_scheduler #(.DATA_WIDTH(DW), .NUM_FILTERS(NF), .IN_CHANNEL(IC), .MAC_WIDTH(MW),
                       .ACC_WIDTH(AW), .RESULT_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .win_ready(win_ready),
    .win_consume(win_consume), .mac_issue(mac_issue), .mac_filter_idx(mac_filter_idx),
    .mac_channel_idx(mac_channel_idx), .result_valid(result_valid), .result_data(result_data),
    .conv_out(conv_out), .conv_valid(conv_valid), .conv_ready(conv_ready), .sched_err(sched_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected pixels: per filter, sum over channels, then clamp to [0, 255].
  function automatic logic [NF*DW-1:0] ref_model(input int t [NF][IC]);
    logic [NF*DW-1:0] r;
    r = '0;
    for (int f = 0; f < NF; f++) begin
      int s;
      s = 0;
      for (int c = 0; c < IC; c++) s += t[f][c];
      if (s < 0) s = 0;
      else if (s > 255) s = 255;
      r[f*DW +: DW] = DW'(s);
    end
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
    if (rand_ready) conv_ready = 1'($urandom_range(1));
  endtask

  task automatic rand_tbl(output int t [NF][IC]);
    int span;
    span = 60 + 130 * int'($urandom_range(2));
    for (int f = 0; f < NF; f++)
      for (int c = 0; c < IC; c++)
        t[f][c] = int'($urandom_range(2 * span)) - span;
  endtask

  task automatic start_pos(input int t [NF][IC], input bit push, input logic [NF*DW-1:0] e);
    tbl = t;
    if (push) begin
      exp_q.push_back(e);
      exp_acc++;
    end
    win_ready = 1'b1;
  endtask

  task automatic wait_consume(input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick();
      if (win_consume) seen = 1'b1;
    end
    win_ready = 1'b0;
    chk(nm, seen, 1);
  endtask

  task automatic wait_acc();
    for (int k = 0; k < 500 && n_acc < exp_acc; k++) tick();
    chk("accept_count", n_acc, exp_acc);
  endtask

  // MAC stand-in: returns tbl[f][c] exactly L cycles after each issue; can inject a stray result.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      result_valid = 1'b0;
      result_data  = '0;
      if (!rst_n) begin
        pend_q.delete();
      end else begin
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          result_valid = 1'b1;
          result_data  = MW'(pend_q[0].data);
          void'(pend_q.pop_front());
        end else if (spur_req != spur_done) begin
          result_valid = 1'b1;
          result_data  = 16'sd77;
          spur_done++;
        end
        if (mac_issue)
          pend_q.push_back('{due: cyc + L, data: tbl[mac_filter_idx][mac_channel_idx]});
      end
    end
  end

  // Monitor: compare every accepted output against the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && conv_valid && conv_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_output: got 0x%0h with no expected entry", conv_out);
        end else begin
          chk("conv_out", conv_out, exp_q.pop_front());
        end
        n_acc++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_err);
    $fatal(1);
  end

  initial begin
    int t [NF][IC];
    int first, last, tcons, tval, nis, oerr, bad, bad_issue;
    bit seen;
    logic [NF*DW-1:0] held;

    repeat (3) tick();
    chk("rst_conv_valid", conv_valid, 0);
    chk("rst_conv_out", conv_out, 0);
    chk("rst_mac_issue", mac_issue, 0);
    chk("rst_win_consume", win_consume, 0);
    chk("rst_sched_err", sched_err, 0);
    chk("rst_filter_idx", mac_filter_idx, 0);
    chk("rst_channel_idx", mac_channel_idx, 0);
    rst_n = 1'b1;
    tick();

    // Single position with known data and cycle-exact timing.
    for (int f = 0; f < NF; f++)
      for (int c = 0; c < IC; c++) t[f][c] = 10 * (f + 1) + c;
    conv_ready = 1'b1;
    start_pos(t, 1'b1, {8'd93, 8'd63, 8'd33});
    first = -1; last = -1; tcons = -1; tval = -1; nis = 0; oerr = 0;
    for (int k = 0; k < 60 && tval < 0; k++) begin
      tick();
      if (mac_issue) begin
        if (first < 0) first = cyc;
        if (mac_filter_idx != 2'(nis / IC) || mac_channel_idx != 2'(nis % IC)) oerr++;
        nis++;
        last = cyc;
      end
      if (win_consume && tcons < 0) begin
        tcons = cyc;
        win_ready = 1'b0;
      end
      if (conv_valid && tval < 0) tval = cyc;
    end
    chk("issue_count", nis, N);
    chk("issue_contiguous", last - first, N - 1);
    chk("issue_order", oerr, 0);
    chk("consume_cycle", tcons - first, N);
    chk("valid_cycle", tval - first, N + L);
    wait_acc();

    // Saturation at both ends.
    t = '{'{200, 100, 0}, '{-50, 10, 5}, '{255, 0, 0}};
    start_pos(t, 1'b1, {8'd255, 8'd0, 8'd255});
    wait_consume("sat_consume");
    wait_acc();

    // Backpressure: output held, next position blocked until accept.
    conv_ready = 1'b0;
    rand_tbl(t);
    start_pos(t, 1'b1, ref_model(t));
    wait_consume("bp_consume_a");
    rand_tbl(t);
    start_pos(t, 1'b1, ref_model(t));
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick();
      if (conv_valid) seen = 1'b1;
    end
    chk("bp_valid_rise", seen, 1);
    held = conv_out; bad = 0; bad_issue = 0;
    repeat (20) begin
      tick();
      if (conv_out !== held || conv_valid !== 1'b1) bad++;
      if (mac_issue) bad_issue++;
    end
    chk("bp_out_stable", bad, 0);
    chk("bp_no_issue", bad_issue, 0);
    conv_ready = 1'b1;
    tick();
    chk("bp_issue_resume", mac_issue, 1);
    chk("bp_valid_cleared", conv_valid, 0);
    wait_consume("bp_consume_b");
    wait_acc();

    // frame_start during the fifth issue: no output, results flushed, clean restart.
    rand_tbl(t);
    start_pos(t, 1'b0, '0);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      tick();
      if (mac_issue) seen = 1'b1;
    end
    chk("fs_issue_start", seen, 1);
    repeat (4) tick();
    chk("fs_issue4_active", mac_issue, 1);
    frame_start = 1'b1;
    win_ready = 1'b0;
    tick();
    frame_start = 1'b0;
    bad = 0;
    repeat (25) begin
      if (conv_valid || win_consume || mac_issue) bad++;
      tick();
    end
    chk("fs_quiet", bad, 0);
    rand_tbl(t);
    start_pos(t, 1'b1, ref_model(t));
    wait_consume("fs_clean_consume");
    wait_acc();
    chk("fs_no_sched_err", sched_err, 0);

    // Stray result in IDLE sets a sticky error and leaves accumulation intact.
    spur_req++;
    repeat (3) tick();
    chk("spur_err_set", sched_err, 1);
    repeat (10) tick();
    chk("spur_err_sticky", sched_err, 1);
    t = '{'{1, 2, 3}, '{40, -50, 20}, '{100, 100, 100}};
    start_pos(t, 1'b1, {8'd255, 8'd10, 8'd6});
    wait_consume("spur_clean_consume");
    wait_acc();

    // Random positions with random gaps and random downstream readiness.
    rand_ready = 1'b1;
    for (int p = 0; p < 12; p++) begin
      repeat ($urandom_range(3)) tick();
      rand_tbl(t);
      start_pos(t, 1'b1, ref_model(t));
      wait_consume("rand_consume");
    end
    rand_ready = 1'b0;
    conv_ready = 1'b1;
    wait_acc();

    // Asynchronous reset in DRAIN clears outputs at once; a fresh position then works.
    rand_tbl(t);
    start_pos(t, 1'b0, '0);
    wait_consume("ar_consume");
    repeat (2) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("ar_conv_valid", conv_valid, 0);
    chk("ar_conv_out", conv_out, 0);
    chk("ar_mac_issue", mac_issue, 0);
    chk("ar_win_consume", win_consume, 0);
    chk("ar_sched_err", sched_err, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    rand_tbl(t);
    start_pos(t, 1'b1, ref_model(t));
    wait_consume("ar_clean_consume");
    wait_acc();
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
